// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day controller: set-mode states,
// key bit positions, field limits and the 12-hour display mapping (HOUR12_EN).
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_e;

    localparam int K_MODE = 0;
    localparam int K_INC  = 1;
    localparam int K_DEC  = 2;
    localparam int K_CLR  = 3;
    localparam int K_OK   = 4;

    localparam int HOUR_MAX = 23;
    localparam int MS_MAX   = 59;

    // Internal hour 0 shows as 12 AM; 13..23 fold down to 1..11 PM.
    function automatic logic [4:0] hour_to_12(input logic [4:0] h);
        logic [4:0] r;
        r = h;
        if (h == 5'd0) begin
            r = 5'd12;
        end else if (h > 5'd12) begin
            r = h - 5'd12;
        end
        return r;
    endfunction

    function automatic logic hour_is_pm(input logic [4:0] h);
        return (h >= 5'd12);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Tick/key inputs and time-field outputs of the time-of-day controller.
// The pm signal exists only when HOUR12_EN is defined.
interface time_set_ctrl_if;

    logic       tick_1hz;
    logic       tick_10s;
    logic [4:0] key;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] set_field;
    logic       day_carry;
`ifdef HOUR12_EN
    logic       pm;
`endif

    modport master (
        output tick_1hz, tick_10s, key,
`ifdef HOUR12_EN
        input  pm,
`endif
        input  hour, minute, second, set_field, day_carry
    );

    modport slave (
        input  tick_1hz, tick_10s, key,
`ifdef HOUR12_EN
        output pm,
`endif
        output hour, minute, second, set_field, day_carry
    );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) field counter with inc/dec/clear; 1-cycle latency from command to value.
// No backpressure; wrap pulses combinationally when inc takes the value MAX->0.
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic             wrap,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        wrap    = 1'b0;
        if (inc) begin
            if (value_q == MAX_V) begin
                value_d = '0;
                wrap    = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end else if (dec) begin
            value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
        end else if (clr) begin
            value_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= INIT_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/time_set_ctrl.sv
// hh:mm:ss keeper with key-driven set mode; every input event shows on outputs 1 cycle later.
// No backpressure: ticks and keys are single-cycle pulses. HOUR12_EN selects 12-hour display.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int INIT_HOUR = 12,
    parameter int INIT_MIN  = 0,
    parameter int INIT_SEC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    time_set_ctrl_if.slave    bus
);

    state_e state_q, state_d;
    logic   day_carry_q, day_carry_d;

    logic key_any;
    logic k_mode, k_ok, k_inc, k_dec, k_clr;
    logic in_run, in_h, in_m, in_s;

    logic       hour_inc, hour_dec, hour_clr, hour_wrap;
    logic       min_inc,  min_dec,  min_clr,  min_wrap;
    logic       sec_inc,  sec_dec,  sec_clr,  sec_wrap;
    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;

    // Only the highest-priority key acts: mode > confirm > inc > dec > clear.
    assign key_any = |bus.key;
    assign k_mode  = bus.key[K_MODE];
    assign k_ok    = bus.key[K_OK]  & ~bus.key[K_MODE];
    assign k_inc   = bus.key[K_INC] & ~bus.key[K_MODE] & ~bus.key[K_OK];
    assign k_dec   = bus.key[K_DEC] & ~bus.key[K_MODE] & ~bus.key[K_OK] & ~bus.key[K_INC];
    assign k_clr   = bus.key[K_CLR] & ~bus.key[K_MODE] & ~bus.key[K_OK] & ~bus.key[K_INC]
                   & ~bus.key[K_DEC];

    assign in_run = (state_q == RUN);
    assign in_h   = (state_q == SET_H);
    assign in_m   = (state_q == SET_M);
    assign in_s   = (state_q == SET_S);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (k_mode) state_d = SET_H;
            end
            SET_H, SET_M, SET_S: begin
                if (k_mode) begin
                    case (state_q)
                        SET_H:   state_d = SET_M;
                        SET_M:   state_d = SET_S;
                        default: state_d = RUN;
                    endcase
                end else if (k_ok || (bus.tick_10s && !key_any)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Carries ripple only in RUN; edits never spill into the neighbouring field.
    always_comb begin
        sec_inc  = (in_run & bus.tick_1hz) | (in_s & k_inc);
        sec_dec  = in_s & k_dec;
        sec_clr  = in_s & k_clr;
        min_inc  = (in_run & sec_wrap) | (in_m & k_inc);
        min_dec  = in_m & k_dec;
        min_clr  = in_m & k_clr;
        hour_inc = (in_run & min_wrap) | (in_h & k_inc);
        hour_dec = in_h & k_dec;
        hour_clr = in_h & k_clr;
        day_carry_d = in_run & hour_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            day_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            day_carry_q <= day_carry_d;
        end
    end

    wrap_counter #(.WIDTH(6), .MAX(MS_MAX), .INIT(INIT_SEC)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .dec   (sec_dec),
        .clr   (sec_clr),
        .wrap  (sec_wrap),
        .value (sec_q)
    );

    wrap_counter #(.WIDTH(6), .MAX(MS_MAX), .INIT(INIT_MIN)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .dec   (min_dec),
        .clr   (min_clr),
        .wrap  (min_wrap),
        .value (min_q)
    );

    wrap_counter #(.WIDTH(5), .MAX(HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (hour_inc),
        .dec   (hour_dec),
        .clr   (hour_clr),
        .wrap  (hour_wrap),
        .value (hour_q)
    );

    assign bus.minute    = min_q;
    assign bus.second    = sec_q;
    assign bus.set_field = state_q;
    assign bus.day_carry = day_carry_q;

`ifdef HOUR12_EN
    assign bus.hour = hour_to_12(hour_q);
    assign bus.pm   = hour_is_pm(hour_q);
`else
    assign bus.hour = hour_q;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Table-driven bench for time_set_ctrl: each applied cycle pushes its expected
// outputs to a scoreboard that is popped and compared after the clock edge.
module tb_time_set_ctrl;

    localparam logic [4:0] K0   = 5'b00000;
    localparam logic [4:0] KMOD = 5'b00001;
    localparam logic [4:0] KINC = 5'b00010;
    localparam logic [4:0] KDEC = 5'b00100;
    localparam logic [4:0] KCLR = 5'b01000;
    localparam logic [4:0] KOK  = 5'b10000;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] f;
        logic       dc;
    } exp_t;

    typedef struct {
        logic       r;
        logic       t1;
        logic       t10;
        logic [4:0] k;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    time_set_ctrl_if bus_if();

    time_set_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    function automatic exp_t mk(input int h, input int m, input int s, input int f, input logic dc);
        exp_t e;
        e.h  = 5'(h);
        e.m  = 6'(m);
        e.s  = 6'(s);
        e.f  = 2'(f);
        e.dc = dc;
        return e;
    endfunction

    task automatic add(input logic r, input logic t1, input logic t10, input logic [4:0] k,
                       input int h, input int m, input int s, input int f, input logic dc);
        vec_t v;
        v.r   = r;
        v.t1  = t1;
        v.t10 = t10;
        v.k   = k;
        v.e   = mk(h, m, s, f, dc);
        tbl.push_back(v);
    endtask

    function automatic logic [4:0] disp_hour(input logic [4:0] h);
        logic [4:0] r;
        r = h;
`ifdef HOUR12_EN
        if (h == 5'd0) r = 5'd12;
        else if (h > 5'd12) r = h - 5'd12;
`endif
        return r;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        logic ok;
        e = sb_q.pop_front();
        checks++;
        ok = (bus_if.hour == disp_hour(e.h)) && (bus_if.minute == e.m) && (bus_if.second == e.s)
          && (bus_if.set_field == e.f) && (bus_if.day_carry == e.dc);
`ifdef HOUR12_EN
        ok = ok && (bus_if.pm == (e.h >= 5'd12));
`endif
        if (!ok) begin
            failures++;
            $display("FAIL %s: got h=%0d m=%0d s=%0d field=%0d carry=%0d, want h=%0d m=%0d s=%0d field=%0d carry=%0d",
                     tag, bus_if.hour, bus_if.minute, bus_if.second, bus_if.set_field,
                     bus_if.day_carry, disp_hour(e.h), e.m, e.s, e.f, e.dc);
        end
    endtask

    task automatic apply(input logic r, input logic t1, input logic t10, input logic [4:0] k,
                         input exp_t e, input string tag);
        @(negedge clk);
        rst             = r;
        bus_if.tick_1hz = t1;
        bus_if.tick_10s = t10;
        bus_if.key      = k;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        bus_if.tick_1hz = 1'b0;
        bus_if.tick_10s = 1'b0;
        bus_if.key      = K0;

        // rst t1 t10 key        hh mm ss fld carry
        add(1, 0, 0, K0,          12, 0, 0, 0, 0);
        add(0, 0, 0, K0,          12, 0, 0, 0, 0);
        add(0, 1, 0, K0,          12, 0, 1, 0, 0);
        add(0, 1, 0, K0,          12, 0, 2, 0, 0);
        add(0, 1, 0, K0,          12, 0, 3, 0, 0);
        add(0, 0, 0, KINC,        12, 0, 3, 0, 0);
        add(0, 0, 0, KCLR,        12, 0, 3, 0, 0);
        add(0, 0, 1, K0,          12, 0, 3, 0, 0);
        add(0, 1, 0, KMOD,        12, 0, 4, 1, 0);
        add(0, 1, 0, K0,          12, 0, 4, 1, 0);
        add(0, 0, 0, KCLR,         0, 0, 4, 1, 0);
        add(0, 0, 0, KDEC,        23, 0, 4, 1, 0);
        add(0, 0, 0, KINC,         0, 0, 4, 1, 0);
        add(0, 0, 0, KDEC,        23, 0, 4, 1, 0);
        add(0, 0, 0, KMOD,        23, 0, 4, 2, 0);
        add(0, 0, 0, KDEC,        23, 59, 4, 2, 0);
        add(0, 0, 0, KINC,        23, 0, 4, 2, 0);
        add(0, 0, 0, KDEC,        23, 59, 4, 2, 0);
        add(0, 0, 0, KMOD,        23, 59, 4, 3, 0);
        add(0, 0, 0, KDEC,        23, 59, 3, 3, 0);
        add(0, 0, 0, KCLR,        23, 59, 0, 3, 0);
        add(0, 0, 0, KDEC,        23, 59, 59, 3, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, K0, 23, 59, 59, 3, 0);
        add(0, 0, 0, KINC | KDEC, 23, 59, 0, 3, 0);
        add(0, 0, 0, KDEC,        23, 59, 59, 3, 0);
        add(0, 0, 1, K0,          23, 59, 59, 0, 0);
        add(0, 1, 0, K0,           0, 0, 0, 0, 1);
        add(0, 0, 0, K0,           0, 0, 0, 0, 0);
        add(0, 1, 0, K0,           0, 0, 1, 0, 0);
        add(0, 0, 0, KMOD,         0, 0, 1, 1, 0);
        add(0, 0, 0, KINC,         1, 0, 1, 1, 0);
        add(0, 0, 1, KCLR,         0, 0, 1, 1, 0);
        add(0, 0, 1, K0,           0, 0, 1, 0, 0);
        add(0, 1, 0, K0,           0, 0, 2, 0, 0);
        add(0, 0, 0, KMOD | KOK,   0, 0, 2, 1, 0);
        add(0, 0, 0, KOK | KINC | KDEC, 0, 0, 2, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].t1, tbl[i].t10, tbl[i].k, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Walk minute up to 30 in SET_M, then confirm with inc also pressed.
        apply(0, 0, 0, KMOD, mk(0, 0, 2, 1, 0), "to_set_h");
        apply(0, 0, 0, KMOD, mk(0, 0, 2, 2, 0), "to_set_m");
        for (int i = 1; i <= 30; i++) begin
            apply(0, 0, 0, KINC, mk(0, i, 2, 2, 0), $sformatf("min_inc%0d", i));
        end
        apply(0, 0, 0, KOK | KINC, mk(0, 30, 2, 0, 0), "confirm_plus_inc");
        apply(0, 1, 0, K0, mk(0, 30, 3, 0, 0), "tick_after_confirm");

        // Dec outranks clear; then reset in the middle of an edit.
        apply(0, 0, 0, KMOD, mk(0, 30, 3, 1, 0), "reenter_set_h");
        apply(0, 0, 0, KDEC | KCLR, mk(23, 30, 3, 1, 0), "dec_over_clr");
        apply(1, 0, 0, KINC, mk(12, 0, 0, 0, 0), "reset_mid_edit");
        apply(0, 0, 0, K0, mk(12, 0, 0, 0, 0), "after_reset");
        apply(0, 1, 0, K0, mk(12, 0, 1, 0, 0), "tick_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
